// File: rtl/approx_dot_acc.sv
// approx_dot_acc
// Streaming dot-product accumulator that sits after the unsigned 8x8 approximate
// multipliers. Sums one PW-bit product per accepted beat until in_last, or until
// MAX_LEN beats have been taken, then presents the total on a valid/ready result
// port. While the result is presented, no input beat is accepted.
//
// Build option:
//   APPROX_DOT_ACC_SAT_EN  when defined, the sum saturates to all-ones on the first
//                          carry out of ACC_W bits. When undefined, the sum wraps
//                          modulo 2^ACC_W. out_ovf reports the carry in both builds.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, active low
//   in_valid   product beat valid
//   in_ready   block can accept a beat (high while accumulating)
//   in_prod    unsigned product, PW bits
//   in_last    beat is the final product of the vector
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   out_sum    unsigned sum of the vector's products, ACC_W bits
//   out_count  number of products in the vector (1..MAX_LEN), CW bits
//   out_ovf    a carry out of ACC_W bits occurred during the vector
//   out_trunc  vector was force-ended at MAX_LEN without in_last

module approx_dot_acc #(
  parameter int unsigned PW      = 16,
  parameter int unsigned ACC_W   = 24,
  parameter int unsigned MAX_LEN = 256,
  parameter int unsigned CW      = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PW-1:0]    in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CW-1:0]    out_count,
  output logic             out_ovf,
  output logic             out_trunc
);

  localparam logic StAcc  = 1'b0;
  localparam logic StHold = 1'b1;

  logic             state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CW-1:0]    out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_trunc_q, out_trunc_d;

  logic             accept;
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic [ACC_W-1:0] sum_next;
  logic [CW-1:0]    cnt_n;
  logic             end_vec;

  assign accept  = in_valid & (state_q == StAcc);
  // One extra bit so the carry out of the accumulator is visible.
  assign sum_ext = {1'b0, acc_q} + {{(ACC_W + 1 - PW){1'b0}}, in_prod};
  assign carry   = sum_ext[ACC_W];
  assign cnt_n   = cnt_q + CW'(1);
  assign end_vec = accept & (in_last | (cnt_n == CW'(MAX_LEN)));

`ifdef APPROX_DOT_ACC_SAT_EN
  // Once saturated, any further nonzero product carries again, so the value
  // stays pinned at all-ones for the rest of the vector.
  assign sum_next = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
  assign sum_next = sum_ext[ACC_W-1:0];
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    out_trunc_d = out_trunc_q;
    if (state_q == StAcc) begin
      if (end_vec) begin
        out_sum_d   = sum_next;
        out_count_d = cnt_n;
        out_ovf_d   = ovf_q | carry;
        out_trunc_d = ~in_last;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
        state_d     = StHold;
      end else if (accept) begin
        acc_d = sum_next;
        cnt_d = cnt_n;
        ovf_d = ovf_q | carry;
      end
    end else begin
      // Result stays stable until taken; input reopens on the following cycle.
      if (out_ready) begin
        state_d = StAcc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StAcc;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      out_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
      out_trunc_q <= out_trunc_d;
    end
  end

  assign in_ready  = (state_q == StAcc);
  assign out_valid = (state_q == StHold);
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;
  assign out_trunc = out_trunc_q;

endmodule

// File: tb/tb_approx_dot_acc.sv
// Bench for approx_dot_acc. Two instances: lane 0 (ACC_W=24, MAX_LEN=512) and
// lane 1 (ACC_W=16, MAX_LEN=4). A model keeps exact integer sums per lane and
// derives wrap/saturate/overflow/truncation from them.

module tb_approx_dot_acc;

  localparam int unsigned MaxL0 = 512;
  localparam int unsigned MaxL1 = 4;
  localparam int unsigned AccW0 = 24;
  localparam int unsigned AccW1 = 16;
`ifdef APPROX_DOT_ACC_SAT_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  iv, il, ordy;
  logic [15:0] ip [2];

  logic        rdy_a, ov_a, ovf_a, tr_a;
  logic [23:0] sum_a;
  logic [9:0]  cnt_a;
  logic        rdy_b, ov_b, ovf_b, tr_b;
  logic [15:0] sum_b;
  logic [2:0]  cnt_b;

  approx_dot_acc #(.PW(16), .ACC_W(AccW0), .MAX_LEN(MaxL0)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv[0]),
    .in_ready  (rdy_a),
    .in_prod   (ip[0]),
    .in_last   (il[0]),
    .out_valid (ov_a),
    .out_ready (ordy[0]),
    .out_sum   (sum_a),
    .out_count (cnt_a),
    .out_ovf   (ovf_a),
    .out_trunc (tr_a)
  );

  approx_dot_acc #(.PW(16), .ACC_W(AccW1), .MAX_LEN(MaxL1)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv[1]),
    .in_ready  (rdy_b),
    .in_prod   (ip[1]),
    .in_last   (il[1]),
    .out_valid (ov_b),
    .out_ready (ordy[1]),
    .out_sum   (sum_b),
    .out_count (cnt_b),
    .out_ovf   (ovf_b),
    .out_trunc (tr_b)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  function automatic logic [63:0] rdy_of(input int k);
    return (k == 0) ? {63'd0, rdy_a} : {63'd0, rdy_b};
  endfunction
  function automatic logic [63:0] val_of(input int k);
    return (k == 0) ? {63'd0, ov_a} : {63'd0, ov_b};
  endfunction
  function automatic logic [63:0] sum_of(input int k);
    return (k == 0) ? {40'd0, sum_a} : {48'd0, sum_b};
  endfunction
  function automatic logic [63:0] cnt_of(input int k);
    return (k == 0) ? {54'd0, cnt_a} : {61'd0, cnt_b};
  endfunction
  function automatic logic [63:0] ovf_of(input int k);
    return (k == 0) ? {63'd0, ovf_a} : {63'd0, ovf_b};
  endfunction
  function automatic logic [63:0] tr_of(input int k);
    return (k == 0) ? {63'd0, tr_a} : {63'd0, tr_b};
  endfunction
  function automatic int maxl(input int k);
    return (k == 0) ? int'(MaxL0) : int'(MaxL1);
  endfunction
  function automatic int accw(input int k);
    return (k == 0) ? int'(AccW0) : int'(AccW1);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: exact running sums, result derived at end of vector.
  longint m_acc [2];
  int     m_cnt [2];
  bit     m_hold[2];
  longint e_sum [2];
  int     e_cnt [2];
  bit     e_ovf [2];
  bit     e_tr  [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      longint s;
      longint lim;
      int     c;
      s   = m_acc[k] + longint'(ip[k]);
      c   = m_cnt[k] + 1;
      lim = longint'(1) << accw(k);
      if (!rst_n) begin
        m_acc[k]  <= 0;
        m_cnt[k]  <= 0;
        m_hold[k] <= 1'b0;
      end else if (m_hold[k]) begin
        if (ordy[k]) m_hold[k] <= 1'b0;
      end else if (iv[k]) begin
        if (il[k] || c == maxl(k)) begin
          m_hold[k] <= 1'b1;
          m_acc[k]  <= 0;
          m_cnt[k]  <= 0;
          e_cnt[k]  <= c;
          e_ovf[k]  <= (s >= lim);
          e_tr[k]   <= !il[k];
          e_sum[k]  <= Sat ? ((s >= lim) ? lim - 1 : s) : (s % lim);
        end else begin
          m_acc[k] <= s;
          m_cnt[k] <= c;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("model in_ready lane%0d", k), rdy_of(k), {63'd0, !m_hold[k]});
        chk($sformatf("model out_valid lane%0d", k), val_of(k), {63'd0, m_hold[k]});
        if (m_hold[k]) begin
          chk($sformatf("model out_sum lane%0d", k), sum_of(k), e_sum[k]);
          chk($sformatf("model out_count lane%0d", k), cnt_of(k), 64'(e_cnt[k]));
          chk($sformatf("model out_ovf lane%0d", k), ovf_of(k), {63'd0, e_ovf[k]});
          chk($sformatf("model out_trunc lane%0d", k), tr_of(k), {63'd0, e_tr[k]});
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that took the beat.
  task automatic send(input int k, input logic [15:0] p, input logic l);
    ip[k] = p;
    il[k] = l;
    iv[k] = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (rdy_of(k) == 64'd1) begin
        @(posedge clk);
        #1;
        iv[k] = 1'b0;
        il[k] = 1'b0;
        return;
      end
    end
    chk($sformatf("send timeout lane%0d", k), 64'd0, 64'd1);
    iv[k] = 1'b0;
    il[k] = 1'b0;
  endtask

  task automatic expect_res(input int k, input longint s, input int c, input bit o,
                            input bit tr, input string nm);
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (val_of(k) == 64'd1) begin
        chk({nm, " sum"}, sum_of(k), s);
        chk({nm, " count"}, cnt_of(k), 64'(c));
        chk({nm, " ovf"}, ovf_of(k), {63'd0, o});
        chk({nm, " trunc"}, tr_of(k), {63'd0, tr});
        chk({nm, " in_ready"}, rdy_of(k), 64'd0);
        @(posedge clk);
        #1;
        return;
      end
    end
    chk({nm, " result timeout"}, 64'd0, 64'd1);
  endtask

  task automatic rand_lane(input int k);
    for (int v = 0; v < 40; v++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        int gap;
        logic [15:0] p;
        gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
        p = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 65535))
                                        : 16'($urandom_range(60000, 65535));
        send(k, p, b == len - 1);
      end
    end
  endtask

  bit rdone;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with valid beats pending
    rst_n = 1'b0;
    iv    = 2'b11;
    il    = 2'b00;
    ip[0] = 16'd5;
    ip[1] = 16'd5;
    ordy  = 2'b11;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset in_ready lane%0d", k), rdy_of(k), 64'd1);
      chk($sformatf("reset out_valid lane%0d", k), val_of(k), 64'd0);
      chk($sformatf("reset out_sum lane%0d", k), sum_of(k), 64'd0);
      chk($sformatf("reset out_count lane%0d", k), cnt_of(k), 64'd0);
      chk($sformatf("reset out_ovf lane%0d", k), ovf_of(k), 64'd0);
      chk($sformatf("reset out_trunc lane%0d", k), tr_of(k), 64'd0);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    iv    = 2'b00;
    repeat (2) begin
      @(posedge clk);
      #1;
    end

    // Basic vector
    send(0, 16'd100, 1'b0);
    send(0, 16'd200, 1'b0);
    send(0, 16'd300, 1'b1);
    expect_res(0, 600, 3, 1'b0, 1'b0, "vec600");

    // Backpressure: result held, input beats refused
    ordy[0] = 1'b0;
    send(0, 16'd10, 1'b0);
    send(0, 16'd20, 1'b1);
    expect_res(0, 30, 2, 1'b0, 1'b0, "bp first");
    for (int i = 0; i < 5; i++) begin
      iv[0] = 1'b1;
      ip[0] = 16'd999;
      @(negedge clk);
      chk("bp held sum", sum_of(0), 64'd30);
      chk("bp in_ready", rdy_of(0), 64'd0);
      @(posedge clk);
      #1;
    end
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    send(0, 16'd1, 1'b0);
    send(0, 16'd2, 1'b1);
    expect_res(0, 3, 2, 1'b0, 1'b0, "bp next");

    // Overflow: 257 beats of 65535
    for (int i = 0; i < 256; i++) send(0, 16'hffff, 1'b0);
    send(0, 16'hffff, 1'b1);
    expect_res(0, Sat ? 64'd16777215 : 64'd65279, 257, 1'b1, 1'b0, "ovf");

    // Truncation at MAX_LEN=4
    for (int i = 0; i < 4; i++) send(1, 16'd1, 1'b0);
    expect_res(1, 4, 4, 1'b0, 1'b1, "trunc");
    send(1, 16'd1, 1'b1);
    expect_res(1, 1, 1, 1'b0, 1'b0, "after trunc");

    // Reset mid-vector
    send(0, 16'd50, 1'b0);
    send(0, 16'd50, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(0, 16'd7, 1'b1);
    expect_res(0, 7, 1, 1'b0, 1'b0, "midreset");

    // Random traffic on both lanes with random result backpressure
    rdone = 1'b0;
    fork
      begin
        fork
          rand_lane(0);
          rand_lane(1);
        join
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clk);
          #1;
          ordy = 2'($urandom_range(0, 3) | $urandom_range(0, 3));
        end
      end
    join
    ordy = 2'b11;
    repeat (5) begin
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
